// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main controller.
// Sequences fetch / decode / execute / memory / writeback for each
// instruction and drives every datapath mux select and write enable.
// Adds BNE, ORI, JAL, a variable-latency memory handshake and a defined
// trap path for illegal opcodes.
//
// Memory handshake: a memory request (memread or memwrite) is held
// asserted for as long as the controller sits in a memory state; the
// access completes on the rising edge where mem_ready=1. In FETCH the IR
// and PC loads (irwrite/pcwrite) are qualified by mem_ready so they fire
// exactly once, on the completing cycle. With MEM_WAIT=0 mem_ready is
// ignored and every memory state completes in one cycle.
module mc_main_ctrl #(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_ORI       = 1'b1,
  parameter bit EN_JAL       = 1'b1,
  parameter bit MEM_WAIT     = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic       memtoreg,
  output logic       jal_link,
  output logic       immzext,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  // Opcodes understood by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Encodings 13 and 14 are deliberately unused and fall to the default arm.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   mem_rdy;

  // Optional opcodes collapse to plain compares when enabled.
  logic op_bne_ok, op_ori_ok, op_jal_ok;

  assign op_bne_ok = EN_BNE && (op == OP_BNE);
  assign op_ori_ok = EN_ORI && (op == OP_ORI);
  assign op_jal_ok = EN_JAL && (op == OP_JAL);

  // Without a wait-capable memory every access completes immediately.
  assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State register and the one-cycle illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection and Moore output decode; reset forces all to 0.
  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    regwrite   = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 1'b0;
    jal_link   = 1'b0;
    immzext    = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = illegal_q;
    state_o    = state_q;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed by the ALU; IR and PC load on the completing cycle.
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_rdy;
        pcwrite = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut while the op is decoded.
        alusrcb = 2'b11;
        if (op == OP_RTYPE) begin
          state_d = S_RTYPE_EX;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = S_MEMADR;
        end else if ((op == OP_BEQ) || op_bne_ok) begin
          state_d = S_BRANCH;
        end else if ((op == OP_ADDI) || op_ori_ok) begin
          state_d = S_IMM_EX;
        end else if (op == OP_J) begin
          state_d = S_JUMP;
        end else if (op_jal_ok) begin
          state_d = S_JAL;
        end else if (ILLEGAL_TRAP) begin
          state_d = S_TRAP;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          // IR changed under us; abandon rather than guess.
          state_d = S_FETCH;
        end
      end

      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end

      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPE_WB;
      end

      S_RTYPE_WB: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        // The datapath combines branch/branch_ne with the ALU zero flag.
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = (op == OP_BEQ);
        branch_ne = op_bne_ok;
        state_d   = S_FETCH;
      end

      S_IMM_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op_ori_ok) begin
          aluop   = 2'b11;
          immzext = 1'b1;
        end
        state_d = S_IMM_WB;
      end

      S_IMM_WB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end

      S_JAL: begin
        // r31 receives the current PC, which FETCH already advanced to PC+4.
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        jal_link = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        // Sticky until reset; nothing else is driven.
        illegal_op = 1'b1;
        state_d    = S_TRAP;
      end

      default: begin
        // Unreachable encodings recover to FETCH with every output low.
        illegal_op = 1'b0;
        state_d    = S_FETCH;
      end
    endcase

    if (reset) begin
      state_d    = S_FETCH;
      illegal_d  = 1'b0;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      regwrite   = 1'b0;
      regdst     = 2'b00;
      memtoreg   = 1'b0;
      jal_link   = 1'b0;
      immzext    = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;
      state_o    = 4'd0;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl. Three instances share clock and inputs:
//   dut_a: all defaults (ILLEGAL_TRAP=1, MEM_WAIT=1)
//   dut_b: EN_BNE=0, ILLEGAL_TRAP=1
//   dut_c: ILLEGAL_TRAP=0, MEM_WAIT=0
// Outputs of each instance are gathered into a 21-bit control word plus
// the 4-bit state, and compared against hand-built expected words.
module tb_mc_main_ctrl;

  // Control word layout, MSB first.
  localparam logic [20:0] IORD      = 21'd1 << 20;
  localparam logic [20:0] MEMREAD   = 21'd1 << 19;
  localparam logic [20:0] MEMWRITE  = 21'd1 << 18;
  localparam logic [20:0] IRWRITE   = 21'd1 << 17;
  localparam logic [20:0] PCWRITE   = 21'd1 << 16;
  localparam logic [20:0] BRANCH    = 21'd1 << 15;
  localparam logic [20:0] BRANCH_NE = 21'd1 << 14;
  localparam logic [20:0] REGWRITE  = 21'd1 << 13;
  localparam logic [20:0] RD_RD     = 21'd1 << 11;
  localparam logic [20:0] RD_R31    = 21'd2 << 11;
  localparam logic [20:0] MEMTOREG  = 21'd1 << 10;
  localparam logic [20:0] JAL_LINK  = 21'd1 << 9;
  localparam logic [20:0] IMMZEXT   = 21'd1 << 8;
  localparam logic [20:0] ALUSRCA   = 21'd1 << 7;
  localparam logic [20:0] SB_4      = 21'd1 << 5;
  localparam logic [20:0] SB_IMM    = 21'd2 << 5;
  localparam logic [20:0] SB_IMM2   = 21'd3 << 5;
  localparam logic [20:0] AO_SUB    = 21'd1 << 3;
  localparam logic [20:0] AO_FN     = 21'd2 << 3;
  localparam logic [20:0] AO_OR     = 21'd3 << 3;
  localparam logic [20:0] PC_OUT    = 21'd1 << 1;
  localparam logic [20:0] PC_J      = 21'd2 << 1;
  localparam logic [20:0] ILLEGAL   = 21'd1;

  localparam logic [20:0] W_NONE     = 21'd0;
  localparam logic [20:0] W_FETCH_RD = MEMREAD | SB_4 | IRWRITE | PCWRITE;
  localparam logic [20:0] W_FETCH_WT = MEMREAD | SB_4;
  localparam logic [20:0] W_DECODE   = SB_IMM2;
  localparam logic [20:0] W_MEMADR   = ALUSRCA | SB_IMM;
  localparam logic [20:0] W_MEMRD    = IORD | MEMREAD;
  localparam logic [20:0] W_MEMWB    = MEMTOREG | REGWRITE;
  localparam logic [20:0] W_MEMWR    = IORD | MEMWRITE;
  localparam logic [20:0] W_RTEX     = ALUSRCA | AO_FN;
  localparam logic [20:0] W_RTWB     = RD_RD | REGWRITE;
  localparam logic [20:0] W_BEQ      = ALUSRCA | AO_SUB | PC_OUT | BRANCH;
  localparam logic [20:0] W_BNE      = ALUSRCA | AO_SUB | PC_OUT | BRANCH_NE;
  localparam logic [20:0] W_ORI      = ALUSRCA | SB_IMM | AO_OR | IMMZEXT;
  localparam logic [20:0] W_ADDI     = ALUSRCA | SB_IMM;
  localparam logic [20:0] W_IMMWB    = REGWRITE;
  localparam logic [20:0] W_JUMP     = PC_J | PCWRITE;
  localparam logic [20:0] W_JAL      = PC_J | PCWRITE | REGWRITE | RD_R31 | JAL_LINK;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  wire [20:0] cw_a, cw_b, cw_c;
  wire [3:0]  st_a, st_b, st_c;

  int total = 0;
  int bad   = 0;

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_main_ctrl dut_a (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(cw_a[20]), .memread(cw_a[19]), .memwrite(cw_a[18]),
    .irwrite(cw_a[17]), .pcwrite(cw_a[16]), .branch(cw_a[15]),
    .branch_ne(cw_a[14]), .regwrite(cw_a[13]), .regdst(cw_a[12:11]),
    .memtoreg(cw_a[10]), .jal_link(cw_a[9]), .immzext(cw_a[8]),
    .alusrca(cw_a[7]), .alusrcb(cw_a[6:5]), .aluop(cw_a[4:3]),
    .pcsrc(cw_a[2:1]), .illegal_op(cw_a[0]), .state_o(st_a)
  );

  mc_main_ctrl #(.EN_BNE(1'b0), .ILLEGAL_TRAP(1'b1)) dut_b (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(cw_b[20]), .memread(cw_b[19]), .memwrite(cw_b[18]),
    .irwrite(cw_b[17]), .pcwrite(cw_b[16]), .branch(cw_b[15]),
    .branch_ne(cw_b[14]), .regwrite(cw_b[13]), .regdst(cw_b[12:11]),
    .memtoreg(cw_b[10]), .jal_link(cw_b[9]), .immzext(cw_b[8]),
    .alusrca(cw_b[7]), .alusrcb(cw_b[6:5]), .aluop(cw_b[4:3]),
    .pcsrc(cw_b[2:1]), .illegal_op(cw_b[0]), .state_o(st_b)
  );

  mc_main_ctrl #(.ILLEGAL_TRAP(1'b0), .MEM_WAIT(1'b0)) dut_c (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(cw_c[20]), .memread(cw_c[19]), .memwrite(cw_c[18]),
    .irwrite(cw_c[17]), .pcwrite(cw_c[16]), .branch(cw_c[15]),
    .branch_ne(cw_c[14]), .regwrite(cw_c[13]), .regdst(cw_c[12:11]),
    .memtoreg(cw_c[10]), .jal_link(cw_c[9]), .immzext(cw_c[8]),
    .alusrca(cw_c[7]), .alusrcb(cw_c[6:5]), .aluop(cw_c[4:3]),
    .pcsrc(cw_c[2:1]), .illegal_op(cw_c[0]), .state_o(st_c)
  );

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Scoreboard compare: which 0=dut_a, 1=dut_b, 2=dut_c.
  task automatic chk(input string tag, input int which,
                     input logic [3:0] es, input logic [20:0] ecw);
    logic [24:0] obs;
    logic [24:0] expv;
    case (which)
      0:       obs = {st_a, cw_a};
      1:       obs = {st_b, cw_b};
      default: obs = {st_c, cw_c};
    endcase
    expv  = {es, ecw};
    total = total + 1;
    assert (obs === expv) else begin
      bad = bad + 1;
      $error("FAIL %s observed state/ctrl=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    reset     = 1'b1;
    op        = OP_RTYPE;
    mem_ready = 1'b1;
    #1;
    chk("rst_a", 0, 4'd0, W_NONE);
    chk("rst_c", 2, 4'd0, W_NONE);
    tick();
    tick();

    // Reset held three cycles in the middle of RTYPE_EX.
    reset = 1'b0;
    #1;
    chk("rt_fetch", 0, 4'd0, W_FETCH_RD);
    tick();
    chk("rt_decode", 0, 4'd1, W_DECODE);
    tick();
    chk("rt_ex", 0, 4'd6, W_RTEX);
    reset = 1'b1;
    #1;
    chk("rst_mid0", 0, 4'd0, W_NONE);
    tick();
    chk("rst_mid1", 0, 4'd0, W_NONE);
    tick();
    chk("rst_mid2", 0, 4'd0, W_NONE);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_release", 0, 4'd0, W_FETCH_RD);
    tick();
    chk("rst_then_dec", 0, 4'd1, W_DECODE);
    tick();
    chk("rt_ex2", 0, 4'd6, W_RTEX);
    tick();
    chk("rt_wb", 0, 4'd7, W_RTWB);
    tick();
    chk("rt_back", 0, 4'd0, W_FETCH_RD);

    // LW with 2 wait cycles in FETCH and 3 in MEMRD.
    do_reset();
    op        = OP_LW;
    mem_ready = 1'b0;
    #1;
    chk("lw_f0", 0, 4'd0, W_FETCH_WT);
    tick();
    chk("lw_f1", 0, 4'd0, W_FETCH_WT);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_f2", 0, 4'd0, W_FETCH_RD);
    tick();
    chk("lw_dec", 0, 4'd1, W_DECODE);
    tick();
    chk("lw_adr", 0, 4'd2, W_MEMADR);
    mem_ready = 1'b0;
    tick();
    chk("lw_rd0", 0, 4'd3, W_MEMRD);
    tick();
    chk("lw_rd1", 0, 4'd3, W_MEMRD);
    tick();
    chk("lw_rd2", 0, 4'd3, W_MEMRD);
    mem_ready = 1'b1;
    #1;
    chk("lw_rd3", 0, 4'd3, W_MEMRD);
    tick();
    chk("lw_wb", 0, 4'd4, W_MEMWB);
    tick();
    chk("lw_back", 0, 4'd0, W_FETCH_RD);

    // MEM_WAIT=0: LW runs in 5 cycles with mem_ready held low.
    do_reset();
    op        = OP_LW;
    mem_ready = 1'b0;
    #1;
    chk("nw_fetch", 2, 4'd0, W_FETCH_RD);
    tick();
    chk("nw_dec", 2, 4'd1, W_DECODE);
    tick();
    chk("nw_adr", 2, 4'd2, W_MEMADR);
    tick();
    chk("nw_rd", 2, 4'd3, W_MEMRD);
    tick();
    chk("nw_wb", 2, 4'd4, W_MEMWB);
    tick();
    chk("nw_back", 2, 4'd0, W_FETCH_RD);

    // SW with memory always ready.
    do_reset();
    op        = OP_SW;
    mem_ready = 1'b1;
    #1;
    chk("sw_fetch", 0, 4'd0, W_FETCH_RD);
    tick();
    chk("sw_dec", 0, 4'd1, W_DECODE);
    tick();
    chk("sw_adr", 0, 4'd2, W_MEMADR);
    tick();
    chk("sw_wr", 0, 4'd5, W_MEMWR);
    tick();
    chk("sw_back", 0, 4'd0, W_FETCH_RD);

    // BEQ then BNE; dut_b has BNE disabled and must trap.
    do_reset();
    op = OP_BEQ;
    tick();
    tick();
    chk("beq_br", 0, 4'd8, W_BEQ);
    tick();
    op = OP_BNE;
    tick();
    tick();
    chk("bne_br", 0, 4'd8, W_BNE);
    chk("bne_trap", 1, 4'd15, ILLEGAL);
    tick();
    chk("bne_back", 0, 4'd0, W_FETCH_RD);
    tick();
    tick();
    tick();
    chk("trap_sticky", 1, 4'd15, ILLEGAL);
    reset = 1'b1;
    #1;
    chk("trap_in_rst", 1, 4'd0, W_NONE);
    tick();
    reset = 1'b0;
    #1;
    chk("trap_cleared", 1, 4'd0, W_FETCH_RD);

    // ORI then ADDI.
    do_reset();
    op = OP_ORI;
    tick();
    tick();
    chk("ori_ex", 0, 4'd9, W_ORI);
    tick();
    chk("ori_wb", 0, 4'd10, W_IMMWB);
    tick();
    op = OP_ADDI;
    tick();
    tick();
    chk("addi_ex", 0, 4'd9, W_ADDI);
    tick();
    chk("addi_wb", 0, 4'd10, W_IMMWB);
    tick();
    chk("addi_back", 0, 4'd0, W_FETCH_RD);

    // JAL then J.
    do_reset();
    op = OP_JAL;
    tick();
    tick();
    chk("jal", 0, 4'd12, W_JAL);
    tick();
    chk("jal_back", 0, 4'd0, W_FETCH_RD);
    op = OP_J;
    tick();
    tick();
    chk("jump", 0, 4'd11, W_JUMP);

    // Illegal op: dut_c pulses for one cycle, dut_a traps.
    do_reset();
    op = OP_BAD;
    #1;
    chk("ill_fetch", 2, 4'd0, W_FETCH_RD);
    tick();
    chk("ill_dec", 2, 4'd1, W_DECODE);
    tick();
    chk("ill_pulse", 2, 4'd0, W_FETCH_RD | ILLEGAL);
    chk("ill_trap_a", 0, 4'd15, ILLEGAL);
    op = OP_RTYPE;
    tick();
    chk("ill_pulse_end", 2, 4'd1, W_DECODE);
    tick();
    chk("ill_recover", 2, 4'd6, W_RTEX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Parametrised successor to the multicycle MIPS main decoder FSM. Sequences FETCH/DECODE/execute/memory/writeback for each instruction and drives every datapath mux and enable.
- Adds BNE, ORI, JAL and a variable-latency memory handshake (mem_ready). Illegal opcodes go to a defined trap path instead of an undefined state.
- Sits between the instruction register opcode field and the multicycle datapath. PC enable = pcwrite | (branch & zero) | (branch_ne & ~zero) is formed in the datapath.

Parameters:
- EN_BNE, 1, decode op 000101 as BNE; if 0, treat it as illegal.
- EN_ORI, 1, decode op 001101 as ORI; if 0, treat it as illegal.
- EN_JAL, 1, decode op 000011 as JAL; if 0, treat it as illegal.
- MEM_WAIT, 1, honour mem_ready; if 0, mem_ready is internally tied to 1.
- ILLEGAL_TRAP, 1, 1: illegal op enters sticky TRAP; 0: pulse illegal_op for one cycle and return to FETCH.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode from IR
- mem_ready  in  1  memory access complete this cycle
- iord  out  1  memory address select (1 = ALUOut)
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load enable
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write if zero
- branch_ne  out  1  PC write if ~zero
- regwrite  out  1  register file write
- regdst  out  2  00 rt, 01 rd, 10 r31
- memtoreg  out  1  writeback data = MDR
- jal_link  out  1  writeback data = PC
- immzext  out  1  zero-extend immediate
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 or
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
- illegal_op  out  1  illegal opcode flag
- state_o  out  4  current state, for debug and verification

Behaviour:
- Single always_ff state register plus a combinational output decode. All outputs are Moore, except that irwrite/pcwrite in FETCH and the state advance in memory states are qualified by mem_ready.
- Every output not listed for a state is 0.
- Reset (synchronous, active-high): state <= FETCH (0). While reset=1, all outputs are forced to 0, state_o=0, and illegal_op clears. Reset mid-instruction aborts the instruction with no further writes.
- State encodings and actions:
  - FETCH 0: memread=1, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE 1: alusrcb=11, aluop=00. Next state by op: 000000→RTYPE_EX, 100011/101011→MEMADR, 000100/000101→BRANCH, 001000/001101→IMM_EX, 000010→JUMP, 000011→JAL, other→ILLEGAL handling.
  - MEMADR 2: alusrca=1, alusrcb=10, aluop=00. LW→MEMRD, SW→MEMWR.
  - MEMRD 3: iord=1, memread=1. Hold until mem_ready, then MEMWB.
  - MEMWB 4: regdst=00, memtoreg=1, regwrite=1. Then FETCH.
  - MEMWR 5: iord=1, memwrite=1, held until mem_ready. Then FETCH.
  - RTYPE_EX 6: alusrca=1, alusrcb=00, aluop=10. Then RTYPE_WB.
  - RTYPE_WB 7: regdst=01, regwrite=1. Then FETCH.
  - BRANCH 8: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 for op 000100, branch_ne=1 for op 000101. Then FETCH.
  - IMM_EX 9: alusrca=1, alusrcb=10. ADDI: aluop=00. ORI: aluop=11, immzext=1. Then IMM_WB.
  - IMM_WB 10: regdst=00, regwrite=1. Then FETCH.
  - JUMP 11: pcsrc=10, pcwrite=1. Then FETCH.
  - JAL 12: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, jal_link=1. The link value is the PC before this write, i.e. the already-incremented PC+4. Then FETCH.
  - TRAP 15: illegal_op=1, all other outputs 0. Stays in TRAP until reset.
- Illegal op handling:
  - ILLEGAL_TRAP=1: DECODE→TRAP.
  - ILLEGAL_TRAP=0: DECODE→FETCH, with illegal_op=1 for exactly the cycle after DECODE (a registered flag).
- op is sampled in DECODE and again in MEMADR/BRANCH/IMM_EX. The IR must be stable, since irwrite=0 outside FETCH.
- Encodings 13 and 14 are unreachable; if entered, the next state is FETCH and all outputs are 0.
- MEM_WAIT=0: every memory state takes exactly one cycle. Latencies are LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ/BNE 3, J 3, JAL 3 cycles.

Test Plan:
- Reset held 3 cycles mid-RTYPE_EX, then released → state_o=0 and all outputs 0 during reset; FETCH with memread=1 on the first cycle after release.
- MEM_WAIT=1, LW (op 100011), mem_ready low 2 cycles in FETCH and 3 in MEMRD → state sequence 0,0,0,1,2,3,3,3,3,4,0; irwrite/pcwrite high only in the third FETCH cycle; regwrite=1, memtoreg=1 only in state 4.
- SW with mem_ready=1 → states 0,1,2,5,0; memwrite=1, iord=1 only in state 5.
- BNE (op 000101) with EN_BNE=1 → state 8 with branch_ne=1, branch=0, aluop=01, pcsrc=01. Repeat with EN_BNE=0, ILLEGAL_TRAP=1 → state 15, illegal_op stuck at 1 until reset.
- ORI then ADDI → state 9 with aluop=11, immzext=1 for ORI and aluop=00, immzext=0 for ADDI; state 10 with regwrite=1, regdst=00 for both.
- JAL (op 000011) → state 12 with pcwrite=1, pcsrc=10, regwrite=1, regdst=10, jal_link=1. Then op 111111 with ILLEGAL_TRAP=0 → return to FETCH with a one-cycle illegal_op pulse.
